// File: rtl/pe_sched_pkg.sv
// Shared types and defaults for the packed dual-MAC dot-product scheduler.
package pe_sched_pkg;

    localparam int INPUT_WIDTH_DEF = 8;
    localparam int K_MAX_DEF       = 256;
    localparam int PE_LATENCY_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_HOLD
    } sched_state_t;

    // One operand triple at the default operand width: A and D share multiplier B.
    typedef struct packed {
        logic [INPUT_WIDTH_DEF-1:0] a;
        logic [INPUT_WIDTH_DEF-1:0] b;
        logic [INPUT_WIDTH_DEF-1:0] d;
    } op_triple_t;

endpackage

// File: rtl/pe_dot_sched_if.sv
// Job, operand, PE and result signals of the dot-product scheduler.
// master = scheduler side, slave = job controller / operand buffer / PE side.
interface pe_dot_sched_if
    import pe_sched_pkg::*;
#(
    parameter int INPUT_WIDTH  = INPUT_WIDTH_DEF,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + 14,
    parameter int CNT_W        = $clog2(K_MAX_DEF + 1)
);
    logic [CNT_W-1:0]        cfg_len;
    logic                    start;
    logic                    busy;
    logic                    err_len;
    logic                    op_valid;
    logic                    op_ready;
    logic [INPUT_WIDTH-1:0]  op_a;
    logic [INPUT_WIDTH-1:0]  op_b;
    logic [INPUT_WIDTH-1:0]  op_d;
    logic [INPUT_WIDTH-1:0]  pe_a;
    logic [INPUT_WIDTH-1:0]  pe_b;
    logic [INPUT_WIDTH-1:0]  pe_d;
    logic                    pe_clr;
    logic                    pe_done;
    logic [OUTPUT_WIDTH-1:0] pe_resulta;
    logic [OUTPUT_WIDTH-1:0] pe_resultb;
    logic                    res_valid;
    logic                    res_ready;
    logic [OUTPUT_WIDTH-1:0] res_a;
    logic [OUTPUT_WIDTH-1:0] res_b;
    logic [15:0]             perf_stall;

    modport master (
        input  cfg_len, start, op_valid, op_a, op_b, op_d,
               pe_resulta, pe_resultb, res_ready,
        output busy, err_len, op_ready, pe_a, pe_b, pe_d, pe_clr, pe_done,
               res_valid, res_a, res_b, perf_stall
    );

    modport slave (
        output cfg_len, start, op_valid, op_a, op_b, op_d,
               pe_resulta, pe_resultb, res_ready,
        input  busy, err_len, op_ready, pe_a, pe_b, pe_d, pe_clr, pe_done,
               res_valid, res_a, res_b, perf_stall
    );

endinterface

// File: rtl/pe_sched_opreg.sv
// PE operand register stage: loads a triple on transfer, otherwise inserts zeros
// so that bubbles, clear and drain cycles contribute nothing to the accumulators.
module pe_sched_opreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic [W-1:0] o_d
);
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
            r_d <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
            r_d <= i_d;
        end else begin
            r_a <= '0;
            r_b <= '0;
            r_d <= '0;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;
    assign o_d = r_d;

endmodule

// File: rtl/pe_dot_sched.sv
// Dot-product job sequencer for a packed dual-MAC PE (sum A*B and sum D*B).
// Optional stall counter on perf_stall enabled by macro PE_DOT_SCHED_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; bad lengths pulse err_len
// S_CLEAR  | one cycle of pe_clr to wipe the PE accumulators
// S_STREAM | op_ready high, operands forwarded until len transfers done
// S_DRAIN  | zeros fed for PE_LATENCY cycles, results captured on the last
// S_HOLD   | res_valid high until the downstream handshake
module pe_dot_sched
    import pe_sched_pkg::*;
#(
    parameter int INPUT_WIDTH  = INPUT_WIDTH_DEF,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + 14,
    parameter int K_MAX        = K_MAX_DEF,
    parameter int PE_LATENCY   = PE_LATENCY_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pe_dot_sched_if.master bus
);
    localparam int CNT_W = $clog2(K_MAX + 1);
    localparam int DRN_W = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] K_MAX_C  = CNT_W'(K_MAX);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PE_LATENCY - 1);

    sched_state_t            r_state;
    logic [CNT_W-1:0]        r_len;
    logic [CNT_W-1:0]        r_cnt;
    logic [DRN_W-1:0]        r_drain;
    logic                    r_err;
    logic                    r_done;
    logic                    r_res_valid;
    logic [OUTPUT_WIDTH-1:0] r_res_a;
    logic [OUTPUT_WIDTH-1:0] r_res_b;

    logic w_len_ok;
    logic w_accept;
    logic w_xfer;

    assign w_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= K_MAX_C);
    assign w_accept = (r_state == S_IDLE) && bus.start && w_len_ok;
    assign w_xfer   = (r_state == S_STREAM) && bus.op_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_a     <= '0;
            r_res_b     <= '0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_len_ok) begin
                            r_len   <= bus.cfg_len;
                            r_cnt   <= '0;
                            r_state <= S_CLEAR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: r_state <= S_STREAM;
                S_STREAM: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt + CNT_W'(1) == r_len) begin
                            r_state <= S_DRAIN;
                            r_drain <= DRN_LOAD;
                            r_done  <= (PE_LATENCY == 1) ? 1'b1 : 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // r_drain counts down to the capture cycle; pe_done is raised one cycle ahead
                    if (r_drain == '0) begin
                        r_res_a     <= bus.pe_resulta;
                        r_res_b     <= bus.pe_resultb;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_drain <= r_drain - DRN_W'(1);
                        r_done  <= (r_drain == DRN_W'(1)) ? 1'b1 : 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    pe_sched_opreg #(.W(INPUT_WIDTH)) u_opreg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_xfer),
        .i_a    (bus.op_a),
        .i_b    (bus.op_b),
        .i_d    (bus.op_d),
        .o_a    (bus.pe_a),
        .o_b    (bus.pe_b),
        .o_d    (bus.pe_d)
    );

`ifdef PE_DOT_SCHED_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if ((r_state == S_STREAM) && !bus.op_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.perf_stall = r_stall;
`else
    assign bus.perf_stall = '0;
`endif

    // The PE clear follows the async reset directly so the accumulators are wiped during reset.
    assign bus.pe_clr    = reset | (r_state == S_CLEAR);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.op_ready  = (r_state == S_STREAM);
    assign bus.err_len   = r_err;
    assign bus.pe_done   = r_done;
    assign bus.res_valid = r_res_valid;
    assign bus.res_a     = r_res_a;
    assign bus.res_b     = r_res_b;

endmodule

// File: tb/tb_pe_dot_sched.sv
// Scoreboard bench for pe_dot_sched: directed and random jobs, a behavioural PE
// model driving pe_result*, and a monitor comparing every result handshake.
`timescale 1ns/1ps
module tb_pe_dot_sched;
    import pe_sched_pkg::*;

    localparam int IW = 8;
    localparam int OW = IW + 14;
    localparam int KM = 256;
    localparam int PL = 4;
    localparam int CW = $clog2(KM + 1);
`ifdef PE_DOT_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [OW-1:0] ra;
        logic [OW-1:0] rb;
        logic [15:0]   stall;
        int            start_cyc;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pe_dot_sched_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CNT_W(CW)) bus ();

    pe_dot_sched #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .K_MAX       (KM),
        .PE_LATENCY  (PL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   hs_count = 0;
    int   rr_hold  = 0;
    bit   rr_rand  = 1'b0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx(input logic [IW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic op_triple_t mk(input int a, input int b, input int d);
        op_triple_t t;
        t.a = a[IW-1:0];
        t.b = b[IW-1:0];
        t.d = d[IW-1:0];
        return t;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // Behavioural PE: accumulate every cycle, result emerges PL-2 cycles after accumulation.
    int acc_a, acc_b;
    int pipe_a[PL-2];
    int pipe_b[PL-2];
    always @(posedge clk or posedge reset) begin
        if (reset || bus.pe_clr) begin
            acc_a <= 0;
            acc_b <= 0;
            for (int i = 0; i < PL - 2; i++) begin
                pipe_a[i] <= 0;
                pipe_b[i] <= 0;
            end
        end else begin
            acc_a <= acc_a + sx(bus.pe_a) * sx(bus.pe_b);
            acc_b <= acc_b + sx(bus.pe_d) * sx(bus.pe_b);
            pipe_a[0] <= acc_a;
            pipe_b[0] <= acc_b;
            for (int i = 1; i < PL - 2; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end
    assign bus.pe_resulta = OW'(pipe_a[PL-3]);
    assign bus.pe_resultb = OW'(pipe_b[PL-3]);

    // Downstream ready: optionally withheld for rr_hold valid cycles, else random or always high.
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rr_hold > 0 && bus.res_valid) begin
                bus.res_ready = 1'b0;
                rr_hold--;
            end else if (rr_rand) begin
                bus.res_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.res_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every result handshake.
    initial begin
        logic          prev_rv;
        logic          prev_done;
        logic          chk_idle;
        logic [OW-1:0] held_a;
        logic [OW-1:0] held_b;
        exp_t          e;
        prev_rv   = 1'b0;
        prev_done = 1'b0;
        chk_idle  = 1'b0;
        held_a    = '0;
        held_b    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_rv   = 1'b0;
                prev_done = 1'b0;
                chk_idle  = 1'b0;
            end else begin
                if (chk_idle) begin
                    check("busy_after_handshake", bus.busy, 0);
                    check("res_valid_after_handshake", bus.res_valid, 0);
                    chk_idle = 1'b0;
                end
                if (bus.res_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_res_valid", 1, 0);
                    end else begin
                        if (!prev_rv) begin
                            check("result_latency", cyc - sb_q[0].start_cyc, sb_q[0].lat);
                            check("pe_done_before_valid", prev_done, 1);
                        end else begin
                            check("res_a_stable", bus.res_a, held_a);
                            check("res_b_stable", bus.res_b, held_b);
                        end
                        held_a = bus.res_a;
                        held_b = bus.res_b;
                        if (bus.res_ready) begin
                            e = sb_q.pop_front();
                            check("res_a", bus.res_a, e.ra);
                            check("res_b", bus.res_b, e.rb);
                            check("perf_stall", bus.perf_stall, e.stall);
                            hs_count++;
                            chk_idle = 1'b1;
                        end
                    end
                end
                prev_rv   = bus.res_valid && !bus.res_ready;
                prev_done = bus.pe_done;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_ready) check("op_ready_timeout", 0, 1);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (hs_count < target) check("result_timeout", hs_count, target);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input op_triple_t ops[$], input int bub[$], input bit start_in_drain);
        exp_t e;
        int   sa = 0;
        int   sb = 0;
        int   tot = 0;
        for (int i = 0; i < ops.size(); i++) begin
            sa  += sx(ops[i].a) * sx(ops[i].b);
            sb  += sx(ops[i].d) * sx(ops[i].b);
            tot += bub[i];
        end
        e.ra        = OW'(sa);
        e.rb        = OW'(sb);
        e.stall     = PERF ? 16'(tot) : 16'd0;
        e.start_cyc = cyc;
        e.lat       = ops.size() + 2 + PL + tot;
        sb_q.push_back(e);
        bus.cfg_len = CW'(ops.size());
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready();
        for (int i = 0; i < ops.size(); i++) begin
            for (int j = 0; j < bub[i]; j++) begin
                bus.op_valid = 1'b0;
                bus.op_a     = 8'($urandom);
                @(negedge clk);
            end
            bus.op_valid = 1'b1;
            bus.op_a     = ops[i].a;
            bus.op_b     = ops[i].b;
            bus.op_d     = ops[i].d;
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        if (start_in_drain) begin
            bus.cfg_len = CW'(2);
            bus.start   = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_triple_t ops[$];
        int         bub[$];
        int         len;
        int         hs_before;
        bus.start    = 1'b0;
        bus.cfg_len  = '0;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.op_d     = '0;
        reset        = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_pe_clr", bus.pe_clr, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_op_ready", bus.op_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_err_len", bus.err_len, 0);
        check("rst_pe_a", bus.pe_a, 0);
        check("rst_perf_stall", bus.perf_stall, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_pe_clr", bus.pe_clr, 0);
        check("idle_busy", bus.busy, 0);
        @(negedge clk);

        // Reference job, continuous operands
        ops = {}; bub = {};
        ops.push_back(mk(2, 3, 1));   bub.push_back(0);
        ops.push_back(mk(-4, 5, -2)); bub.push_back(0);
        ops.push_back(mk(1, 1, 1));   bub.push_back(0);
        run_job(ops, bub, 1'b0);
        wait_hs(1);

        // Same job with bubbles between operands
        bub = {};
        bub.push_back(0); bub.push_back(1); bub.push_back(1);
        run_job(ops, bub, 1'b0);
        wait_hs(2);

        // Rejected lengths
        for (int t = 0; t < 2; t++) begin
            bus.cfg_len = (t == 0) ? CW'(0) : CW'(KM + 1);
            bus.start   = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check("err_len_pulse", bus.err_len, 1);
            check("err_busy", bus.busy, 0);
            check("err_op_ready", bus.op_ready, 0);
            @(negedge clk);
            #1;
            check("err_len_clear", bus.err_len, 0);
            check("err_busy_after", bus.busy, 0);
            @(negedge clk);
        end

        // Result held while downstream is not ready
        ops = {}; bub = {};
        ops.push_back(mk(-128, -128, 127)); bub.push_back(0);
        rr_hold = 5;
        run_job(ops, bub, 1'b0);
        wait_hs(3);

        // Asynchronous reset during the second STREAM cycle abandons the job
        bus.cfg_len = CW'(4);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready();
        bus.op_valid = 1'b1;
        bus.op_a = 8'd5; bus.op_b = 8'd6; bus.op_d = 8'd7;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_op_ready", bus.op_ready, 0);
        check("arst_pe_a", bus.pe_a, 0);
        check("arst_pe_b", bus.pe_b, 0);
        check("arst_pe_d", bus.pe_d, 0);
        check("arst_pe_clr", bus.pe_clr, 1);
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_pe_done", bus.pe_done, 0);
        bus.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_arst_busy", bus.busy, 0);
        @(negedge clk);
        ops = {}; bub = {};
        ops.push_back(mk(1, 1, 1)); bub.push_back(0);
        run_job(ops, bub, 1'b0);
        wait_hs(4);

        // start during DRAIN must be dropped
        ops = {}; bub = {};
        ops.push_back(mk(7, -3, 2)); bub.push_back(0);
        ops.push_back(mk(-6, 4, 9)); bub.push_back(0);
        run_job(ops, bub, 1'b1);
        wait_hs(5);
        hs_before = hs_count;
        repeat (20) @(negedge clk);
        #1;
        check("drain_start_ignored_busy", bus.busy, 0);
        check("drain_start_single_handshake", hs_count, hs_before);
        @(negedge clk);

        // Random jobs, including one of maximum length
        rr_rand = 1'b1;
        for (int j = 0; j < 14; j++) begin
            ops = {}; bub = {};
            len = (j == 6) ? KM : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                ops.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                 int'($urandom_range(0, 255))));
                bub.push_back(int'($urandom_range(0, 2)));
            end
            run_job(ops, bub, 1'b0);
            wait_hs(6 + j);
        end
        rr_rand = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
